// File: rtl/exu_alu_arb_pkg.sv
// exu_alu_arb_pkg: shared types for the ALU arbiter.
package exu_alu_arb_pkg;
    typedef enum logic [0:0] {ARB_NORM, ARB_FORCE} alu_arb_state_t;
    localparam logic ALU_ARB_REQ0 = 1'b0;
    localparam logic ALU_ARB_REQ1 = 1'b1;
    typedef struct packed {
        logic add;
        logic sub;
        logic land;
        logic lor;
        logic lxor;
        logic beq;
        logic bne;
        logic jal;
    } alu_pkt_t;
endpackage

// File: rtl/exu_alu_arb_starve.sv
// exu_alu_arb_starve: req1 starvation counter and forced-grant FSM.
module exu_alu_arb_starve
    import exu_alu_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze_i,
    input  logic             req1_valid_i,
    input  logic             req1_ready_i,
    output logic             force_o,
    output logic [CNT_W-1:0] starve_cnt_o
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);
    alu_arb_state_t   state_q, state_d, state_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Reaching the limit takes effect in the same cycle so req1 wins immediately.
    always_comb begin
        state_eff = (state_q == ARB_NORM && cnt_q == MAX && req1_valid_i) ? ARB_FORCE : state_q;
        state_d   = (state_eff == ARB_FORCE && (req1_ready_i || !req1_valid_i)) ? ARB_NORM : state_eff;
        cnt_d     = (!req1_valid_i || req1_ready_i) ? '0 :
                    (freeze_i || cnt_q == MAX) ? cnt_q : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_NORM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign force_o      = state_eff == ARB_FORCE;
    assign starve_cnt_o = cnt_q;
endmodule

// File: rtl/exu_alu_arb.sv
// exu_alu_arb: shares one ALU between the issue pipe (req0) and the aux port (req1),
// with a one-cycle tagged response path and bounded req1 latency.
module exu_alu_arb
    import exu_alu_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [30:0]      req0_pc,
    input  logic [11:0]      req0_brimm,
    input  alu_pkt_t         req0_ap,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  alu_pkt_t         req1_ap,
    output logic             alu_valid,
    output logic             alu_enable,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [30:0]      alu_pc,
    output logic [11:0]      alu_brimm,
    output alu_pkt_t         alu_ap,
    input  logic [31:0]      alu_out,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [31:0]      rsp_data,
    output logic [CNT_W-1:0] starve_cnt
);
    logic v0, g0, g1, force_arb;
    logic owner_q, owner_d, inflight_q, inflight_d;

    exu_alu_arb_starve #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_starve (
        .clk          (clk),
        .rst          (rst),
        .freeze_i     (freeze),
        .req1_valid_i (req1_valid),
        .req1_ready_i (g1),
        .force_o      (force_arb),
        .starve_cnt_o (starve_cnt)
    );

    // req1 wins only when the pipe is idle, or when forced; grants are mutually exclusive.
    assign v0 = req0_valid & ~flush;
    assign g1 = ~rst & ~freeze & req1_valid & (force_arb | ~v0);
    assign g0 = ~rst & ~freeze & v0 & ~g1;

    always_comb begin
        alu_a      = g0 ? req0_a : g1 ? req1_a : '0;
        alu_b      = g0 ? req0_b : g1 ? req1_b : '0;
        alu_ap     = g0 ? req0_ap : g1 ? req1_ap : '0;
        alu_pc     = g0 ? req0_pc : '0;
        alu_brimm  = g0 ? req0_brimm : '0;
        owner_d    = g1 ? ALU_ARB_REQ1 : ALU_ARB_REQ0;
        inflight_d = g0 | g1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= ALU_ARB_REQ0;
            inflight_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            inflight_q <= inflight_d;
        end
    end

    assign req0_ready = g0;
    assign req1_ready = g1;
    assign alu_valid  = g0 | g1;
    assign alu_enable = g0 | g1;
    assign rsp0_valid = ~rst & inflight_q & (owner_q == ALU_ARB_REQ0) & ~flush;
    assign rsp1_valid = ~rst & inflight_q & (owner_q == ALU_ARB_REQ1);
    assign rsp_data   = alu_out;
endmodule

// File: tb/tb_exu_alu_arb.sv
// tb_exu_alu_arb: directed scoreboard bench for the ALU arbiter with a one-cycle ALU model.
module tb_exu_alu_arb;
    import exu_alu_arb_pkg::*;
    localparam alu_pkt_t AP_ADD = alu_pkt_t'(8'h80);
    localparam alu_pkt_t AP_SUB = alu_pkt_t'(8'h40);

    logic clk = 1'b0;
    logic rst, freeze, flush;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [30:0] req0_pc;
    logic [11:0] req0_brimm;
    alu_pkt_t req0_ap, req1_ap, alu_ap;
    logic alu_valid, alu_enable, rsp0_valid, rsp1_valid;
    logic [31:0] alu_a, alu_b, alu_out, rsp_data;
    logic [30:0] alu_pc;
    logic [11:0] alu_brimm;
    logic [7:0] starve_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] sb[$];
    logic [32:0] mon_e;

    exu_alu_arb #(.STARVE_MAX(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_pc(req0_pc), .req0_brimm(req0_brimm), .req0_ap(req0_ap),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ap(req1_ap),
        .alu_valid(alu_valid), .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b),
        .alu_pc(alu_pc), .alu_brimm(alu_brimm), .alu_ap(alu_ap), .alu_out(alu_out),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] calc(alu_pkt_t ap, logic [31:0] a, logic [31:0] b);
        return ap.add ? a + b : ap.sub ? a - b : ap.land ? a & b :
               ap.lor ? a | b : ap.lxor ? a ^ b : 32'h0;
    endfunction

    always @(posedge clk) alu_out <= calc(alu_ap, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    task automatic expect_rsp(input logic owner, input logic [31:0] d);
        sb.push_back({owner, d});
    endtask

    always @(negedge clk) begin
        if (rsp0_valid || rsp1_valid) begin
            if (sb.size() == 0) check("rsp_unexpected", 32'(rsp1_valid) + 32'h10 * 32'(rsp0_valid), 32'h0);
            else begin
                mon_e = sb.pop_front();
                check("rsp_owner", 32'(rsp1_valid), 32'(mon_e[32]));
                check("rsp_excl", 32'(rsp0_valid & rsp1_valid), 32'h0);
                check("rsp_data", rsp_data, mon_e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        req0_pc = 31'h1234; req0_brimm = 12'habc; req0_ap = AP_ADD; req1_ap = AP_SUB;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 1, 2, 2);
        #1;
        check("rst_rdy0", 32'(req0_ready), 0);
        check("rst_rdy1", 32'(req1_ready), 0);
        check("rst_alu_valid", 32'(alu_valid), 0);
        check("rst_rsp0", 32'(rsp0_valid), 0);
        check("rst_rsp1", 32'(rsp1_valid), 0);
        check("rst_cnt", 32'(starve_cnt), 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        // single req0 add
        tick();
        drive(1, 5, 3, 0, 0, 0);
        #1;
        check("t1_rdy0", 32'(req0_ready), 1);
        check("t1_rdy1", 32'(req1_ready), 0);
        check("t1_alu_en", 32'(alu_enable), 1);
        check("t1_alu_a", alu_a, 5);
        check("t1_alu_pc", 32'(alu_pc), 32'h1234);
        check("t1_alu_brimm", 32'(alu_brimm), 32'habc);
        expect_rsp(0, 8);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("t1_rsp0", 32'(rsp0_valid), 1);
        check("t1_idle_valid", 32'(alu_valid), 0);
        check("t1_idle_a", alu_a, 0);
        check("t1_idle_ap", 32'(alu_ap), 0);
        check("t1_idle_pc", 32'(alu_pc), 0);
        // both valid: three req0 wins, then forced req1
        for (int c = 1; c <= 5; c++) begin
            tick();
            drive(1, c, 10, 1, 100, c);
            #1;
            check("t2_cnt", 32'(starve_cnt), (c == 5) ? 0 : c - 1);
            if (c == 4) begin
                check("t2_force_rdy1", 32'(req1_ready), 1);
                check("t2_force_rdy0", 32'(req0_ready), 0);
                check("t2_force_pc", 32'(alu_pc), 0);
                expect_rsp(1, 32'(100 - c));
            end else begin
                check("t2_rdy0", 32'(req0_ready), 1);
                check("t2_rdy1", 32'(req1_ready), 0);
                expect_rsp(0, 32'(c + 10));
            end
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        // flush kills req0 response but not req1
        tick();
        drive(1, 7, 2, 0, 0, 0);
        #1;
        check("t3_rdy0", 32'(req0_ready), 1);
        tick();
        flush = 1'b1;
        drive(1, 7, 2, 0, 0, 0);
        #1;
        check("t3_rsp0_flushed", 32'(rsp0_valid), 0);
        check("t3_rdy0_flush", 32'(req0_ready), 0);
        check("t3_alu_valid_flush", 32'(alu_valid), 0);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 1, 9, 4);
        #1;
        check("t3_rdy1", 32'(req1_ready), 1);
        expect_rsp(1, 5);
        tick();
        flush = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("t3_rsp1", 32'(rsp1_valid), 1);
        check("t3_rsp1_data", rsp_data, 5);
        tick();
        flush = 1'b0;
        // freeze blocks grants and holds the counter
        tick();
        drive(1, 20, 1, 1, 50, 1);
        #1;
        check("t4_rdy0", 32'(req0_ready), 1);
        expect_rsp(0, 21);
        for (int i = 0; i < 5; i++) begin
            tick();
            freeze = 1'b1;
            #1;
            check("t4_frz_rdy0", 32'(req0_ready), 0);
            check("t4_frz_rdy1", 32'(req1_ready), 0);
            check("t4_frz_valid", 32'(alu_valid), 0);
            check("t4_frz_cnt", 32'(starve_cnt), 1);
        end
        tick();
        freeze = 1'b0;
        drive(1, 30, 1, 1, 50, 1);
        #1;
        check("t4_resume_rdy0", 32'(req0_ready), 1);
        expect_rsp(0, 31);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        // enter FORCE under freeze, then req1 withdraws
        for (int c = 0; c < 3; c++) begin
            tick();
            drive(1, c, 1, 1, 60, 1);
            expect_rsp(0, 32'(c + 1));
        end
        tick();
        freeze = 1'b1;
        #1;
        check("t5_frz_valid", 32'(alu_valid), 0);
        check("t5_frz_cnt", 32'(starve_cnt), 3);
        tick();
        freeze = 1'b0;
        drive(1, 40, 2, 0, 0, 0);
        #1;
        check("t5_rdy0", 32'(req0_ready), 1);
        expect_rsp(0, 42);
        tick();
        drive(1, 41, 2, 1, 60, 1);
        #1;
        check("t5_cnt0", 32'(starve_cnt), 0);
        check("t5_norm_rdy0", 32'(req0_ready), 1);
        check("t5_norm_rdy1", 32'(req1_ready), 0);
        expect_rsp(0, 43);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        // reset drops in-flight responses and clears FSM state
        tick();
        drive(1, 3, 2, 0, 0, 0);
        tick();
        rst = 1'b1;
        drive(1, 3, 2, 1, 70, 1);
        #1;
        check("t6_rsp0", 32'(rsp0_valid), 0);
        check("t6_rdy0", 32'(req0_ready), 0);
        check("t6_rdy1", 32'(req1_ready), 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 70, 1);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rsp1", 32'(rsp1_valid), 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1, c, 4, 1, 70, 1);
            expect_rsp(0, 32'(c + 4));
            tick();
        end
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 5, 5, 1, 70, 1);
        #1;
        check("t6_cnt", 32'(starve_cnt), 0);
        check("t6_norm_rdy0", 32'(req0_ready), 1);
        check("t6_norm_rdy1", 32'(req1_ready), 0);
        expect_rsp(0, 10);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
